// File: rtl/shared_bus_if.sv
// Core-to-bus handshake bundle shared by the two core masters and the arbiter.
interface shared_bus_if #(
    parameter int unsigned DATA_W = 32
);
    logic              core_a_req;
    logic [DATA_W-1:0] core_a_data;
    logic              core_a_last;
    logic              core_b_req;
    logic [DATA_W-1:0] core_b_data;
    logic              core_b_last;
    logic              bus_grant_a;
    logic              bus_grant_b;
    logic [DATA_W-1:0] bus_data;
    logic              bus_valid;
    logic              bus_preempt;

    // Core side: presents requests and beats, observes grants and the bus.
    modport master (
        output core_a_req, core_a_data, core_a_last,
        output core_b_req, core_b_data, core_b_last,
        input  bus_grant_a, bus_grant_b, bus_data, bus_valid, bus_preempt
    );

    // Arbiter side: consumes requests and beats, drives grants and the bus.
    modport slave (
        input  core_a_req, core_a_data, core_a_last,
        input  core_b_req, core_b_data, core_b_last,
        output bus_grant_a, bus_grant_b, bus_data, bus_valid, bus_preempt
    );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin tenure arbiter for two cores sharing one bus, with burst
// ownership and a MAX_BURST limit that only bites when the other core waits.
module shared_bus_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CNT_W     = 8
) (
    input logic       clk,
    input logic       rst,
    shared_bus_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t            state;
    logic              prio;       // 0 favours A, 1 favours B
    logic [CNT_W-1:0]  beat_cnt;

    logic              own_req_c;
    logic              own_last_c;
    logic [DATA_W-1:0] own_data_c;
    logic              other_req_c;
    logic              accept_c;
    logic              preempt_c;
    logic              release_c;

    // Select the current owner's signals and decide accept / preempt / release.
    always_comb begin
        own_req_c   = 1'b0;
        own_last_c  = 1'b0;
        own_data_c  = '0;
        other_req_c = 1'b0;
        case (state)
            GRANT_A: begin
                own_req_c   = bus.core_a_req;
                own_last_c  = bus.core_a_last;
                own_data_c  = bus.core_a_data;
                other_req_c = bus.core_b_req;
            end
            GRANT_B: begin
                own_req_c   = bus.core_b_req;
                own_last_c  = bus.core_b_last;
                own_data_c  = bus.core_b_data;
                other_req_c = bus.core_a_req;
            end
            default: ;
        endcase
        accept_c  = (state != IDLE) && own_req_c;
        // A last beat that also hits the limit counts as a normal release.
        preempt_c = accept_c && !own_last_c && (beat_cnt >= LIMIT_M1) && other_req_c;
        release_c = (state != IDLE) && (!own_req_c || own_last_c || preempt_c);
    end

    // Arbitration FSM, beat counter, priority bit and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            prio            <= 1'b0;
            beat_cnt        <= '0;
            bus.bus_grant_a <= 1'b0;
            bus.bus_grant_b <= 1'b0;
            bus.bus_data    <= '0;
            bus.bus_valid   <= 1'b0;
            bus.bus_preempt <= 1'b0;
        end else begin
            bus.bus_valid   <= accept_c;
            bus.bus_preempt <= preempt_c;
            if (accept_c) begin
                bus.bus_data <= own_data_c;
                if (beat_cnt < CNT_SAT) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (bus.core_a_req && (!bus.core_b_req || !prio)) begin
                        state           <= GRANT_A;
                        bus.bus_grant_a <= 1'b1;
                        beat_cnt        <= '0;
                    end else if (bus.core_b_req) begin
                        state           <= GRANT_B;
                        bus.bus_grant_b <= 1'b1;
                        beat_cnt        <= '0;
                    end
                end
                GRANT_A, GRANT_B: begin
                    if (release_c) begin
                        state           <= IDLE;
                        bus.bus_grant_a <= 1'b0;
                        bus.bus_grant_b <= 1'b0;
                        prio            <= (state == GRANT_A);
                    end
                end
                default: begin
                    state           <= IDLE;
                    bus.bus_grant_a <= 1'b0;
                    bus.bus_grant_b <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: directed scenarios plus randomized traffic
// checked against a tenure-level reference model.
module tb_shared_bus_arbiter;

    localparam int MAXB = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    shared_bus_if #(.DATA_W(32)) bif ();

    shared_bus_arbiter #(
        .DATA_W   (32),
        .MAX_BURST(MAXB),
        .CNT_W    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    // {grant_a, grant_b, valid, preempt}
    logic [3:0] flags;
    assign flags = {bif.bus_grant_a, bif.bus_grant_b, bif.bus_valid, bif.bus_preempt};

    always #5 clk = ~clk;

    // Reference model: owner 0 none / 1 A / 2 B, beats counted without limit.
    int          m_owner;
    int          m_prio;
    int          m_beats;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_pre;

    // Advance the model by the upcoming clock edge using the inputs now driven.
    task automatic model_advance();
        logic        req;
        logic        oreq;
        logic        lst;
        logic [31:0] d;
        if (rst) begin
            m_owner = 0; m_prio = 0; m_beats = 0;
            m_data = 32'h0; m_valid = 1'b0; m_pre = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_pre   = 1'b0;
            if (m_owner == 0) begin
                if (bif.core_a_req && (!bif.core_b_req || m_prio == 0)) begin
                    m_owner = 1; m_beats = 0;
                end else if (bif.core_b_req) begin
                    m_owner = 2; m_beats = 0;
                end
            end else begin
                req  = (m_owner == 1) ? bif.core_a_req  : bif.core_b_req;
                oreq = (m_owner == 1) ? bif.core_b_req  : bif.core_a_req;
                lst  = (m_owner == 1) ? bif.core_a_last : bif.core_b_last;
                d    = (m_owner == 1) ? bif.core_a_data : bif.core_b_data;
                if (req) begin
                    m_valid = 1'b1;
                    m_data  = d;
                    m_beats = m_beats + 1;
                    if (!lst && m_beats >= MAXB && oreq) m_pre = 1'b1;
                end
                if (!req || lst || m_pre) begin
                    m_prio  = (m_owner == 1) ? 1 : 0;
                    m_owner = 0;
                end
            end
        end
    endtask

    // One clock: update the model, then land on the sampling (falling) edge.
    task automatic tick();
        model_advance();
        @(negedge clk);
    endtask

    task automatic set_in(input logic ar, input logic [31:0] ad, input logic al,
                          input logic br, input logic [31:0] bd, input logic bl);
        bif.core_a_req = ar; bif.core_a_data = ad; bif.core_a_last = al;
        bif.core_b_req = br; bif.core_b_data = bd; bif.core_b_last = bl;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_in(1, 32'hDEAD, 0, 1, 32'hBEEF, 0);
        rst = 1'b1;
        tick();
        n_checks++;
        if (flags !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", flags);
        end
        n_checks++;
        if (bif.bus_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", bif.bus_data);
        end
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_single_core();
        logic [3:0]  ef [5];
        logic [31:0] ed [5];
        logic [31:0] ad [5];
        logic        al [5];
        logic        ar [5];
        do_reset();
        ar = '{1, 1, 1, 1, 0};
        ad = '{32'h11, 32'h11, 32'h22, 32'h33, 32'h0};
        al = '{0, 0, 0, 1, 0};
        ef = '{4'b1000, 4'b1010, 4'b1010, 4'b0010, 4'b0000};
        ed = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h33};
        for (int i = 0; i < 5; i++) begin
            set_in(ar[i], ad[i], al[i], 0, 0, 0);
            tick();
            n_checks++;
            if (flags !== ef[i] || bif.bus_data !== ed[i]) begin
                n_fail++;
                $display("FAIL single_core[%0d]: got flags %b data %h want %b %h",
                         i, flags, bif.bus_data, ef[i], ed[i]);
            end
        end
        // prio now favours B: a simultaneous request must go to B
        set_in(1, 32'h1, 0, 1, 32'h2, 0);
        tick();
        n_checks++;
        if (flags !== 4'b0100) begin
            n_fail++; $display("FAIL single_core_prio: got %b want 0100", flags);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_in(1, 32'hAA, 0, 1, 32'hBB, 0);
        tick();
        n_checks++;
        if (flags !== 4'b1000) begin
            n_fail++; $display("FAIL simul_first: got %b want 1000", flags);
        end
        tick();
        set_in(1, 32'hA1, 1, 1, 32'hBB, 0);
        tick();
        n_checks++;
        if (flags !== 4'b0010 || bif.bus_data !== 32'hA1) begin
            n_fail++; $display("FAIL simul_bubble: got %b %h want 0010 a1", flags, bif.bus_data);
        end
        set_in(1, 32'hA2, 0, 1, 32'hBB, 0);
        tick();
        n_checks++;
        if (flags !== 4'b0100) begin
            n_fail++; $display("FAIL simul_grant_b: got %b want 0100", flags);
        end
        set_in(1, 32'hA2, 0, 1, 32'hB1, 1);
        tick();
        n_checks++;
        if (flags !== 4'b0010 || bif.bus_data !== 32'hB1) begin
            n_fail++; $display("FAIL simul_b_last: got %b %h want 0010 b1", flags, bif.bus_data);
        end
        set_in(1, 32'hA2, 0, 1, 32'hB2, 0);
        tick();
        n_checks++;
        if (flags !== 4'b1000) begin
            n_fail++; $display("FAIL simul_back_to_a: got %b want 1000", flags);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        set_in(1, 32'h0, 0, 1, 32'hB0, 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 32'(i), 0, 1, 32'hB0, 0);
            tick();
            n_checks++;
            if (flags !== ((i < 4) ? 4'b1010 : 4'b0011) || bif.bus_data !== 32'(i)) begin
                n_fail++;
                $display("FAIL preempt_beat%0d: got %b %h", i, flags, bif.bus_data);
            end
        end
        tick();
        n_checks++;
        if (flags !== 4'b0100) begin
            n_fail++; $display("FAIL preempt_handoff: got %b want 0100", flags);
        end
    endtask

    task automatic test_uncontested();
        do_reset();
        set_in(1, 32'h100, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            set_in(1, 32'h100 + 32'(i), 0, 0, 0, 0);
            tick();
            n_checks++;
            if (flags !== 4'b1010 || bif.bus_data !== 32'h100 + 32'(i)) begin
                n_fail++;
                $display("FAIL uncontested_beat%0d: got %b %h want 1010", i, flags, bif.bus_data);
            end
        end
        // counter saturated: the first beat seen with B waiting preempts
        set_in(1, 32'h200, 0, 1, 32'hB0, 0);
        tick();
        n_checks++;
        if (flags !== 4'b0011 || bif.bus_data !== 32'h200) begin
            n_fail++; $display("FAIL uncontested_late_preempt: got %b %h want 0011 200", flags, bif.bus_data);
        end
    endtask

    task automatic test_last_at_limit();
        do_reset();
        set_in(0, 0, 0, 1, 32'h40, 0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 32'hA0, 0, 1, 32'h40 + 32'(i), (i == 4));
            tick();
            n_checks++;
            if (flags !== ((i < 4) ? 4'b0110 : 4'b0010)) begin
                n_fail++; $display("FAIL last_limit_beat%0d: got %b", i, flags);
            end
        end
        set_in(1, 32'hA0, 0, 1, 32'h50, 0);
        tick();
        n_checks++;
        if (flags !== 4'b1000) begin
            n_fail++; $display("FAIL last_limit_next: got %b want 1000", flags);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(1, 32'h51, 0, 0, 0, 0);
        tick();
        tick();
        n_checks++;
        if (flags !== 4'b1010 || bif.bus_data !== 32'h51) begin
            n_fail++; $display("FAIL rstmid_beat1: got %b %h", flags, bif.bus_data);
        end
        set_in(1, 32'h52, 0, 1, 32'hB2, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (flags !== 4'b0000 || bif.bus_data !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_cleared: got %b %h want 0000 0", flags, bif.bus_data);
        end
        tick();
        n_checks++;
        if (flags !== 4'b1000 || bif.bus_data !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_restart: got %b %h want 1000 0", flags, bif.bus_data);
        end
    endtask

    task automatic test_random();
        logic [3:0] ef;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            set_in(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 3) == 0));
            tick();
            ef = {m_owner == 1, m_owner == 2, m_valid, m_pre};
            n_checks++;
            if (flags !== ef) begin
                n_fail++; $display("FAIL random_flags cyc %0d: got %b want %b", c, flags, ef);
            end
            n_checks++;
            if (bif.bus_data !== m_data) begin
                n_fail++; $display("FAIL random_data cyc %0d: got %h want %h", c, bif.bus_data, m_data);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_checks = 0;
        n_fail = 0;
        m_owner = 0; m_prio = 0; m_beats = 0;
        m_data = 32'h0; m_valid = 1'b0; m_pre = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        test_reset();
        test_single_core();
        test_simultaneous();
        test_preempt();
        test_uncontested();
        test_last_at_limit();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_bus_arbiter.md
# shared_bus_arbiter

Sequential arbiter that shares the 32-bit system bus between core A (big core) and core B (little core). It replaces fixed A-priority with round-robin tenure arbitration, burst ownership, and a bounded burst length so neither core can starve the other. It sits between the two core bus masters and the shared bus, and registers the winning core's data onto the bus.

## Interface
- DATA_W, 32, width of core and bus data.
- MAX_BURST, 16, max beats per tenure while the other core waits; legal range 1..255.
- CNT_W, 8, beat counter width; must hold MAX_BURST.

- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- core_a_req  input  1  core A requests the bus / presents a beat.
- core_a_data  input  DATA_W  core A beat data.
- core_a_last  input  1  marks core A's final beat of the burst.
- core_b_req  input  1  core B request.
- core_b_data  input  DATA_W  core B beat data.
- core_b_last  input  1  core B final beat.
- bus_grant_a  output  1  core A owns the bus (registered).
- bus_grant_b  output  1  core B owns the bus (registered).
- bus_data  output  DATA_W  registered accepted beat.
- bus_valid  output  1  bus_data holds a beat this cycle.
- bus_preempt  output  1  one-cycle pulse: tenure ended by the MAX_BURST limit.

## Operation
- States: IDLE, GRANT_A, GRANT_B. The grants are decoded from state; at most one grant is ever high.
- prio bit: 0 favours A, 1 favours B. Reset value is 0.
- IDLE:
  - Only A requests: next state GRANT_A.
  - Only B requests: next state GRANT_B.
  - Both request: grant goes to the core selected by prio.
  - Neither requests: stay in IDLE.
- Beat accept: a beat is accepted in a cycle where the state is GRANT_X and core_x_req=1. The next cycle shows bus_data=core_x_data and bus_valid=1. Otherwise bus_valid=0 and bus_data holds its value.
- Beat counter:
  - Cleared on entering GRANT_X.
  - Increments per accepted beat.
  - Saturates at MAX_BURST.
- Release from GRANT_X to IDLE happens on any one of these:
  - (a) An accepted beat with core_x_last=1.
  - (b) core_x_req=0 while granted. No beat is accepted.
  - (c) An accepted beat that is the MAX_BURST-th of the tenure while the other core's req=1. This also pulses bus_preempt next cycle.
- On every release, prio is set to favour the other core.
- If the other core is idle, the tenure continues past MAX_BURST with the counter saturated. Preemption fires on the first accepted beat at which the count is already ≥ MAX_BURST-1 and the other core's req=1.
- If (a) and (c) coincide, it is treated as (a) and bus_preempt stays 0.
- A released core that still requests re-arbitrates from IDLE under the updated prio.

## Timing
- Reset values: bus_grant_a=0, bus_grant_b=0, bus_valid=0, bus_data=0, bus_preempt=0. State is IDLE, prio=0, counter=0.
- Request-to-grant latency: req high in IDLE at edge t gives grant high after edge t+1 (one cycle).
- Beat latency: one cycle from acceptance to bus_valid.
- Handoff: the release cycle is t. Grant drops at t+1 (IDLE, one mandatory bubble). The new grant is asserted at t+2.
- The last beat's bus_valid appears at t+1, coinciding with the bubble.
- bus_preempt is high for exactly the one cycle after the forcing beat.
- Reset mid-tenure: at the reset edge all outputs and state take their reset values. Any beat presented that cycle is discarded, and no bus_valid follows it.
- Reset dominates all other inputs in the same cycle.

## Test plan
- Single core: A requests 3 beats (0x11, 0x22, 0x33 with last on 0x33), B idle. Required:
  - grant_a rises one cycle after req.
  - bus_valid is high for 3 cycles carrying 0x11, 0x22, 0x33.
  - grant_a drops after the last beat; prio becomes 1.
- Simultaneous request from reset: both req high. Required:
  - A is granted first.
  - After A's last beat, one IDLE cycle follows, then grant_b.
  - A re-requesting alternates correctly: B wins, then A.
- Preemption with MAX_BURST=4: A streams with no last while B requests continuously. Required:
  - After A's 4th accepted beat, grant_a drops.
  - bus_preempt pulses once.
  - grant_b rises two cycles after the 4th beat.
- No preemption when uncontested: A streams 20 beats and B is idle. Required:
  - grant_a stays high for all 20 beats.
  - bus_preempt stays 0 and the counter saturates.
- Last coinciding with limit: B's 4th beat carries last while A is waiting. Required: release occurs with bus_preempt=0.
- Reset mid-burst: assert rst during A's 2nd beat. Required:
  - Next cycle, all outputs are 0 and the state is IDLE.
  - No bus_valid appears for the discarded beat.
  - Arbitration restarts with A favoured.
